// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding and default baud/data-width
// constants, kept common with the transmitter so both ends agree on timing.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS_DEF        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

  // Plain-vector copies of the encoding for logic-typed state registers.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BRK    = 3'd5;

  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; RESET_VAL sets the
// level both flops hold in reset (1 suits idle-high serial lines and buttons).
module sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= {WIDTH{RESET_VAL}};
      r_sync <= {WIDTH{RESET_VAL}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with a one-deep
// valid/ready holding register and framing/overrun (and parity) error pulses.
//   state  | meaning
//   IDLE   | line idle, waiting for a low level
//   START  | timing to mid start bit, rejects short glitches
//   DATA   | sampling data bits LSB first, one per bit period
//   PARITY | sampling the even parity bit (parity build only)
//   STOP   | sampling the stop bit, deciding deliver or framing error
//   BRK    | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_par_bad;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_done;
  logic                 r_frame_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx_in),
    .o_q     (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (r_state == ST_PARITY && r_cnt == BIT_LAST) begin
        r_par_bad    <= ^{r_shift, w_rx_s};
        r_parity_err <= ^{r_shift, w_rx_s};
      end
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_done  <= !w_par_bad;
              r_state <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BRK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_BRK: begin
          // A held-low line stays here so it reports only one framing error.
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The shift register is stable for the cycle after the stop sample because
  // a new frame cannot reach DATA that quickly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_busy     = (r_state != ST_IDLE);
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive end of the serial link driven by the sum/latch transmitter path.
- Deserialises 8N1 frames from an asynchronous line.
- Presents each byte on a one-deep valid/ready holding register.
- Flags framing and overrun errors; lets the top level loop back or inspect transmitted sums.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); minimum 4.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_in  in  1  serial line; asynchronous; idles high
- rx_data  out  DATA_BITS  received byte; stable while rx_valid is high
- rx_valid  out  1  byte available in the holding register
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready
- rx_busy  out  1  frame reception in progress
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun_err  out  1  one-cycle pulse: completed byte dropped because the holding register was full

Behaviour:
- Reset (async assert, sync release):
  - 2-FF synchroniser regs = 1; state = IDLE; counters = 0; shift reg = 0.
  - rx_data = 0; rx_valid, rx_busy, frame_err, overrun_err = 0.
- Synchroniser: rx_in passes through 2 flops; all logic uses the synchronised rx_s.
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index: width $clog2(DATA_BITS+1).
- FSM:
  - IDLE: rx_s==0 -> START, bit counter cleared.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit).
    - rx_s still 0 -> DATA, counters cleared.
    - rx_s 1 -> IDLE (glitch rejected; no error).
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift reg MSB and shift right.
    - After DATA_BITS samples -> STOP (or PARITY when the optional feature is enabled).
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1 -> deliver byte, go to IDLE.
    - 0 -> frame_err pulse, byte discarded, go to BRK.
  - BRK: wait until rx_s==1, then IDLE. A held-low line produces exactly one frame_err.
- rx_busy = (state != IDLE).
- Delivery, in the cycle after the stop sample:
  - rx_valid==0 -> rx_data <= shift reg; rx_valid <= 1.
  - rx_valid==1 and rx_ready==1 in the same cycle -> new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid==1 and rx_ready==0 -> old byte retained, new byte dropped, overrun_err pulse.
- Handshake: rx_valid clears the cycle after rx_valid && rx_ready. rx_data must not change while rx_valid==1 unless accepted.
- Latency from rx_in falling edge to rx_valid: 2 (sync) + CLKS_PER_BIT/2 + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles, ±1.
- Reset mid-frame: all state cleared immediately; the partial byte is lost. After release, the receiver waits in IDLE for the next falling edge; a line still low enters START and is rejected unless it is a valid mid-bit low.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1.
  - PARITY state between DATA and STOP samples one bit at mid-bit.
  - Adds output parity_err (1-bit, one-cycle pulse) when the data bits XOR the parity bit != 0 (even parity).
  - Byte is discarded on parity error; the STOP check still runs.
  - Latency increases by CLKS_PER_BIT.
- Undefined: 8N1, no PARITY state, no parity_err port.

Decomposition:
- Package uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP, BRK); DEFAULT_CLKS_PER_BIT = 434; DATA_BITS_DEF = 8.
  - Shared with the existing transmitter for baud consistency.
- Sub-module sync_2ff: generic 2-flop synchroniser with reset value parameter 1, reused for the async button inputs.

Test Plan (sim with CLKS_PER_BIT=16):
- Send 0xA5, rx_ready=1 -> rx_valid for one cycle with rx_data=0xA5; frame_err=0; rx_busy low after the stop sample.
- 4-cycle low glitch on idle line -> returns to IDLE, no rx_valid, no frame_err.
- Send 0x3C with stop bit forced 0, line held low 40 bit times -> exactly one frame_err pulse, no rx_valid; after line goes high, 0x81 is received correctly.
- Send 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun_err pulses once at the second stop sample; raise rx_ready -> 0x11 accepted, rx_valid drops.
- Assert rx_ready exactly in the delivery cycle of the second byte -> 0x22 loaded, rx_valid stays high, no overrun_err.
- Assert reset_n=0 mid data bit 4 of 0xFF -> all outputs 0 immediately; after release, send 0x5A -> 0x5A received. With UART_RX_PARITY_EN, 0x07 with odd parity bit -> parity_err pulse, no rx_valid.
